serial_tx_shifter: RTL and testbench

//  Parallel-to-serial stage feeding the serial bit-sequence checker's Din input.

---
 rtl/serial_pkg.sv | 22 ++
 rtl/serial_bit_counter.sv | 29 ++
 rtl/serial_tx_shifter.sv | 157 +++++++++++++++
 tb/tb_serial_tx_shifter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared state encoding and default constants for the serial TX path.
package serial_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    localparam int   DEF_WIDTH      = 8;
    localparam int   DEF_GAP_BITS   = 1;
    localparam logic DEF_IDLE_LEVEL = 1'b0;

    // One counter serves both SHIFT and GAP, so size it for the larger load.
    function automatic int cnt_w(input int width, input int gap);
        int m;
        m = (gap > width) ? gap : width;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/serial_bit_counter.sv
// Loadable down-counter with terminal-count flag; saturates at zero.
module serial_bit_counter #(
    parameter int CW = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_dec,
    output logic [CW-1:0] o_count,
    output logic          o_tc
);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == '0);

endmodule

// File: rtl/serial_tx_shifter.sv
// Parallel-to-serial TX stage with idle gap between words.
// Define SERIAL_TX_PARITY_EN to append an even-parity bit to each frame.
module serial_tx_shifter
    import serial_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_BITS   = DEF_GAP_BITS,
    parameter bit IDLE_LEVEL = DEF_IDLE_LEVEL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             Dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             frame_done
);

    localparam int            CW       = cnt_w(WIDTH, GAP_BITS);
    localparam bit            HAS_GAP  = (GAP_BITS > 0);
    localparam logic [CW-1:0] LD_SHIFT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] LD_GAP   = CW'(HAS_GAP ? GAP_BITS - 1 : 0);

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic             r_dout;
    logic             r_dout_valid;
    logic             r_frame_done;
`ifdef SERIAL_TX_PARITY_EN
    logic             r_par;
`endif

    logic             w_load;
    logic             w_dec;
    logic [CW-1:0]    w_ld_val;
    logic [CW-1:0]    w_cnt;
    logic             w_tc;
    logic             w_first_bit;
    logic             w_next_bit;
    logic [WIDTH-1:0] w_first_shift;
    logic [WIDTH-1:0] w_next_shift;

    assign w_first_bit   = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
    assign w_first_shift = MSB_FIRST ? (data_in << 1) : (data_in >> 1);
    assign w_next_bit    = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
    assign w_next_shift  = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);

    always_comb begin
        w_load   = 1'b0;
        w_dec    = 1'b0;
        w_ld_val = LD_SHIFT;
        case (r_state)
            S_IDLE: w_load = data_valid;
            S_SHIFT: begin
                w_dec = !w_tc;
`ifndef SERIAL_TX_PARITY_EN
                if (w_tc && HAS_GAP) begin
                    w_load   = 1'b1;
                    w_ld_val = LD_GAP;
                end
`endif
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: begin
                if (HAS_GAP) begin
                    w_load   = 1'b1;
                    w_ld_val = LD_GAP;
                end
            end
`endif
            S_GAP: w_dec = !w_tc;
            default: ;
        endcase
    end

    serial_bit_counter #(.CW(CW)) u_cnt (
        .i_clk      (clk),
        .i_rst_n    (reset),
        .i_load     (w_load),
        .i_load_val (w_ld_val),
        .i_dec      (w_dec),
        .o_count    (w_cnt),
        .o_tc       (w_tc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_dout       <= IDLE_LEVEL;
            r_dout_valid <= 1'b0;
            r_frame_done <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            r_par        <= 1'b0;
`endif
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (data_valid) begin
                        r_state      <= S_SHIFT;
                        r_shift      <= w_first_shift;
                        r_dout       <= w_first_bit;
                        r_dout_valid <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
                        r_par        <= ^data_in;
`endif
                    end
                end
                S_SHIFT: begin
                    if (!w_tc) begin
                        r_dout  <= w_next_bit;
                        r_shift <= w_next_shift;
`ifndef SERIAL_TX_PARITY_EN
                        r_frame_done <= (w_cnt == CW'(1));
`endif
                    end else begin
`ifdef SERIAL_TX_PARITY_EN
                        r_state      <= S_PARITY;
                        r_dout       <= r_par;
                        r_frame_done <= 1'b1;
`else
                        r_state      <= HAS_GAP ? S_GAP : S_IDLE;
                        r_dout       <= IDLE_LEVEL;
                        r_dout_valid <= 1'b0;
`endif
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                S_PARITY: begin
                    r_state      <= HAS_GAP ? S_GAP : S_IDLE;
                    r_dout       <= IDLE_LEVEL;
                    r_dout_valid <= 1'b0;
                end
`endif
                S_GAP: begin
                    if (w_tc) r_state <= S_IDLE;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_dout       <= IDLE_LEVEL;
                    r_dout_valid <= 1'b0;
                end
            endcase
        end
    end

    assign data_ready = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign Dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_serial_tx_shifter.sv
// Directed bench for serial_tx_shifter: three parameterisations share one stimulus.
// Honours SERIAL_TX_PARITY_EN for the expected frame length.
module tb_serial_tx_shifter;

`ifdef SERIAL_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = 8 + PAR;

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic [7:0] din    = 8'h00;
    logic       dvalid = 1'b0;

    logic a_rdy, a_dout, a_dv, a_busy, a_fd;
    logic b_rdy, b_dout, b_dv, b_busy, b_fd;
    logic c_rdy, c_dout, c_dv, c_busy, c_fd;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_tx_shifter #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_BITS(1), .IDLE_LEVEL(1'b0)) u_a (
        .clk(clk), .reset(reset), .data_in(din), .data_valid(dvalid),
        .data_ready(a_rdy), .Dout(a_dout), .dout_valid(a_dv),
        .busy(a_busy), .frame_done(a_fd)
    );

    serial_tx_shifter #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_BITS(1), .IDLE_LEVEL(1'b0)) u_b (
        .clk(clk), .reset(reset), .data_in(din), .data_valid(dvalid),
        .data_ready(b_rdy), .Dout(b_dout), .dout_valid(b_dv),
        .busy(b_busy), .frame_done(b_fd)
    );

    serial_tx_shifter #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_BITS(0), .IDLE_LEVEL(1'b0)) u_c (
        .clk(clk), .reset(reset), .data_in(din), .data_valid(dvalid),
        .data_ready(c_rdy), .Dout(c_dout), .dout_valid(c_dv),
        .busy(c_busy), .frame_done(c_fd)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        dvalid = 1'b0;
        reset  = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    function automatic logic ebit(input logic [7:0] w, input int i, input bit msb);
        if (i >= 8) return ^w;
        return msb ? w[7-i] : w[i];
    endfunction

    task automatic test_reset;
        reset  = 1'b0;
        dvalid = 1'b0;
        #2;
        n_cmp++;
        if ({a_dout, a_dv, a_busy, a_fd} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_outs: got %b want 0000", {a_dout, a_dv, a_busy, a_fd});
        end
        tick();
        reset = 1'b1;
        tick();
        n_cmp++;
        if ({a_rdy, a_busy} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_ready: got %b want 10", {a_rdy, a_busy});
        end
    endtask

    task automatic test_msb_first;
        logic [7:0] w;
        w = 8'hA5;
        do_reset();
        din = w; dvalid = 1'b1;
        tick();
        dvalid = 1'b0; din = 8'h00;
        for (int i = 0; i < FL; i++) begin
            n_cmp++;
            if ({a_dout, a_dv, a_busy} !== {ebit(w, i, 1'b1), 2'b11}) begin
                n_err++;
                $display("FAIL msb_bit%0d: got %b want %b", i,
                         {a_dout, a_dv, a_busy}, {ebit(w, i, 1'b1), 2'b11});
            end
            n_cmp++;
            if (a_fd !== (i == FL - 1)) begin
                n_err++;
                $display("FAIL msb_fd%0d: got %b want %b", i, a_fd, (i == FL - 1));
            end
            tick();
        end
        n_cmp++;
        if ({a_dout, a_dv, a_busy, a_rdy} !== 4'b0010) begin
            n_err++;
            $display("FAIL msb_gap: got %b want 0010", {a_dout, a_dv, a_busy, a_rdy});
        end
        tick();
        n_cmp++;
        if ({a_rdy, a_busy} !== 2'b10) begin
            n_err++;
            $display("FAIL msb_ready_back: got %b want 10", {a_rdy, a_busy});
        end
    endtask

    task automatic test_lsb_first;
        logic [7:0] w;
        int run, maxrun;
        w = 8'h07;
        run = 0; maxrun = 0;
        do_reset();
        din = w; dvalid = 1'b1;
        tick();
        dvalid = 1'b0;
        for (int i = 0; i < FL; i++) begin
            n_cmp++;
            if ({b_dout, b_dv, b_busy} !== {ebit(w, i, 1'b0), 2'b11}) begin
                n_err++;
                $display("FAIL lsb_bit%0d: got %b want %b", i,
                         {b_dout, b_dv, b_busy}, {ebit(w, i, 1'b0), 2'b11});
            end
            n_cmp++;
            if (b_fd !== (i == FL - 1)) begin
                n_err++;
                $display("FAIL lsb_fd%0d: got %b want %b", i, b_fd, (i == FL - 1));
            end
            run = b_dout ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
            tick();
        end
        n_cmp++;
        if (maxrun != 3) begin
            n_err++;
            $display("FAIL lsb_run: got %0d want 3", maxrun);
        end
        tick();
        n_cmp++;
        if ({b_rdy, b_dout} !== 2'b10) begin
            n_err++;
            $display("FAIL lsb_idle: got %b want 10", {b_rdy, b_dout});
        end
    endtask

`ifdef SERIAL_TX_PARITY_EN
    task automatic test_parity;
        logic [7:0] w [2];
        logic       p [2];
        w[0] = 8'hA5; p[0] = 1'b0;
        w[1] = 8'h07; p[1] = 1'b1;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            din = w[k]; dvalid = 1'b1;
            tick();
            dvalid = 1'b0;
            for (int i = 0; i < 8; i++) tick();
            n_cmp++;
            if ({a_dout, a_dv, a_fd} !== {p[k], 2'b11}) begin
                n_err++;
                $display("FAIL parity%0d: got %b want %b", k, {a_dout, a_dv, a_fd}, {p[k], 2'b11});
            end
            tick();
            tick();
        end
    endtask
`endif

    task automatic test_back_to_back;
        logic [7:0] w0, w1;
        w0 = 8'hFF; w1 = 8'h00;
        do_reset();
        din = w0; dvalid = 1'b1;
        tick();
        din = w1;
        for (int i = 0; i < FL; i++) begin
            n_cmp++;
            if ({c_dout, c_dv, c_fd} !== {ebit(w0, i, 1'b1), 1'b1, (i == FL - 1)}) begin
                n_err++;
                $display("FAIL b2b_f0_bit%0d: got %b want %b", i, {c_dout, c_dv, c_fd},
                         {ebit(w0, i, 1'b1), 1'b1, (i == FL - 1)});
            end
            tick();
        end
        n_cmp++;
        if ({c_rdy, c_dv, c_dout} !== 3'b100) begin
            n_err++;
            $display("FAIL b2b_turn: got %b want 100", {c_rdy, c_dv, c_dout});
        end
        tick();
        dvalid = 1'b0;
        for (int i = 0; i < FL; i++) begin
            n_cmp++;
            if ({c_dout, c_dv, c_fd} !== {ebit(w1, i, 1'b1), 1'b1, (i == FL - 1)}) begin
                n_err++;
                $display("FAIL b2b_f1_bit%0d: got %b want %b", i, {c_dout, c_dv, c_fd},
                         {ebit(w1, i, 1'b1), 1'b1, (i == FL - 1)});
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({c_dv, c_busy, c_rdy} !== 3'b001) begin
                n_err++;
                $display("FAIL b2b_nodup%0d: got %b want 001", i, {c_dv, c_busy, c_rdy});
            end
            tick();
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] w;
        w = 8'hF0;
        do_reset();
        din = w; dvalid = 1'b1;
        tick();
        dvalid = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({a_dout, a_dv} !== 2'b11) begin
            n_err++;
            $display("FAIL mid_bit3: got %b want 11", {a_dout, a_dv});
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({a_dout, a_busy, a_dv, a_fd} !== 4'b0000) begin
            n_err++;
            $display("FAIL mid_reset: got %b want 0000", {a_dout, a_busy, a_dv, a_fd});
        end
        #2;
        reset = 1'b1;
        tick();
        n_cmp++;
        if ({a_rdy, a_dv} !== 2'b10) begin
            n_err++;
            $display("FAIL mid_release: got %b want 10", {a_rdy, a_dv});
        end
        w = 8'h3C;
        din = w; dvalid = 1'b1;
        tick();
        dvalid = 1'b0;
        for (int i = 0; i < FL; i++) begin
            n_cmp++;
            if ({a_dout, a_dv, a_fd} !== {ebit(w, i, 1'b1), 1'b1, (i == FL - 1)}) begin
                n_err++;
                $display("FAIL mid_3c_bit%0d: got %b want %b", i, {a_dout, a_dv, a_fd},
                         {ebit(w, i, 1'b1), 1'b1, (i == FL - 1)});
            end
            tick();
        end
        n_cmp++;
        if ({a_dout, a_dv} !== 2'b00) begin
            n_err++;
            $display("FAIL mid_3c_gap: got %b want 00", {a_dout, a_dv});
        end
    endtask

    task automatic test_busy_ignore;
        logic [7:0] w;
        w = 8'h96;
        do_reset();
        din = w; dvalid = 1'b1;
        tick();
        dvalid = 1'b0;
        for (int i = 0; i < FL; i++) begin
            n_cmp++;
            if ({a_dout, a_dv, a_fd} !== {ebit(w, i, 1'b1), 1'b1, (i == FL - 1)}) begin
                n_err++;
                $display("FAIL busy_bit%0d: got %b want %b", i, {a_dout, a_dv, a_fd},
                         {ebit(w, i, 1'b1), 1'b1, (i == FL - 1)});
            end
            din    = ~din;
            dvalid = (i % 2 == 0);
            tick();
        end
        dvalid = 1'b0;
        n_cmp++;
        if ({a_dout, a_dv, a_busy} !== 3'b001) begin
            n_err++;
            $display("FAIL busy_gap: got %b want 001", {a_dout, a_dv, a_busy});
        end
        tick();
        tick();
        n_cmp++;
        if ({a_rdy, a_dv, a_busy} !== 3'b100) begin
            n_err++;
            $display("FAIL busy_noaccept: got %b want 100", {a_rdy, a_dv, a_busy});
        end
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
`ifdef SERIAL_TX_PARITY_EN
        test_parity();
`endif
        test_back_to_back();
        test_reset_mid();
        test_busy_ignore();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
